lfsr_13_descrambler: RTL and testbench
======================================

Name: lfsr_13_descrambler

Overview:
Receive-side counterpart of the 14-bit-per-step, 528-bit LFSR scrambler. Per accepted beat, the block takes the transmitted 528-bit scrambler state. It recovers the 14 serial bits that produced that state from the previous state, then re-runs the scrambler recurrence to check the whole word. It tracks lock and error statistics and presents recovered bits on a registered valid/ready output. It sits at the receive end of the scrambled link, ahead of serial-data consumers.

Parameters:
WIDTH, 528, LFSR state width
STEP, 14, serial bits absorbed per beat
TAP1, 169, first feedback tap (bit i = msb ^ poly[i-1])
TAP2, 283, second feedback tap
TAP3, 401, third feedback tap
LOCK_N, 4, consecutive clean beats required to assert locked
ERR_W, 16, error counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
seed_load  input  1  pulse: load seed_in as previous state
seed_in  input  WIDTH  initial scrambler state (same value as the transmitter's data_load)
in_valid  input  1  state_in valid
in_ready  output  1  beat accepted when in_valid && in_ready
state_in  input  WIDTH  received scrambler state after STEP steps
out_valid  output  1  serial_out/out_err valid
out_ready  input  1  consumer accepts output
serial_out  output  STEP  recovered bits; bit k = the k-th absorbed bit (serial_in[k] at transmitter)
out_err  output  1  beat failed the consistency check
err_count  output  ERR_W  saturating count of failed beats
locked  output  1  LOCK_N consecutive clean beats seen since last seed/error

Behaviour:
- Reset (rst=0 at a clk edge): FSM=UNSEEDED, prev=0, out_valid=0, serial_out=0, out_err=0, err_count=0, locked=0, clean counter=0. Reset takes effect mid-beat and discards any pending output.
- FSM states:
  - UNSEEDED: in_ready=0. seed_load -> RUN.
  - RUN: normal operation.
- seed_load in any state:
  - prev<=seed_in, clean counter<=0, locked<=0.
  - in_ready=0 in that cycle, so seed_load wins over a simultaneous beat.
  - err_count is unchanged. A held output beat is kept.
- In RUN: in_ready = !seed_load && (!out_valid || out_ready). This gives a full-throughput single output register.
- On accept, with P=prev and N=state_in:
  - d[k] = N[STEP-1-k] ^ P[WIDTH-1-k] for k=0..STEP-1. This holds because the top STEP bits contain no taps.
  - E = scrambler applied STEP times to P with inputs d[0..STEP-1]. Per step: bit0=msb^d, tap bits = msb^poly[i-1], all other bits = poly[i-1].
  - mismatch = (E != N).
  - Next cycle: out_valid=1, serial_out=d, out_err=mismatch.
  - prev<=N unconditionally, so the block resyncs to the received state.
- Output: out_valid clears on out_valid&&out_ready unless a new beat is accepted in the same cycle. Latency is 1 cycle from accept to out_valid.
- err_count increments on each mismatching accepted beat and saturates at all-ones.
- Lock: a clean beat increments the clean counter, saturating at LOCK_N. locked=1 when the counter reaches LOCK_N. A mismatch clears the counter and locked in the cycle the result registers. locked and err_count update together with out_valid.
- The recurrence is combinational within one cycle, matching the transmitter's unrolled form.

Decomposition:
- Package lfsr_13_pkg: WIDTH, STEP, TAP1..TAP3 constants, and the single-step scrambler function shared with the transmitter.
- Sub-module lfsr_13_step_unroll: combinational STEP-fold scrambler (P, d) -> E.
- The descrambler owns the FSM, handshake, and counters.

Test Plan:
- Zero seed, single bit: seed_in=0, state_in=528'h2000 -> serial_out=14'h0001, out_err=0, err_count=0.
- Msb seed: seed_in=1<<527, state_in=bits{13,182,296,414} set -> serial_out=14'h0000, out_err=0.
- Corrupted beat: seed 0, state_in=(1<<200)|528'h2000 -> serial_out=14'h0001, out_err=1, err_count=1, locked=0.
- Lock and backpressure: seed 0, 6 valid beats with out_ready held low for 3 cycles.
  - No beat is lost or duplicated, and in_ready=0 while the output is held.
  - locked rises with the 4th clean result.
  - An injected error on beat 5 drops locked.
- Seed collision and reset: assert seed_load together with in_valid -> beat is not accepted and prev=seed_in. Pull rst low mid-stream -> out_valid=0, err_count=0, in_ready=0 until the next seed_load.

Source files
------------

// File: rtl/lfsr_13_pkg.sv
// Shared constants and the single-step scrambler recurrence for the 528-bit LFSR link.
package lfsr_13_pkg;

  localparam int WIDTH   = 528;
  localparam int STEP    = 14;
  localparam int TAP1    = 169;
  localparam int TAP2    = 283;
  localparam int TAP3    = 401;
  localparam int LOCK_N  = 4;
  localparam int ERR_W   = 16;
  localparam int CLEAN_W = $clog2(LOCK_N + 1);

  typedef enum logic {
    ST_UNSEEDED,
    ST_RUN
  } desc_state_e;

  // One scrambler step: shift up, feed msb^d into bit 0, and fold msb into the tap bits.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s, input logic d);
    logic             msb;
    logic [WIDTH-1:0] t;
    msb     = s[WIDTH-1];
    t       = {s[WIDTH-2:0], msb ^ d};
    t[TAP1] = t[TAP1] ^ msb;
    t[TAP2] = t[TAP2] ^ msb;
    t[TAP3] = t[TAP3] ^ msb;
    return t;
  endfunction

endpackage

// File: rtl/lfsr_13_step_unroll.sv
// Combinational STEP-fold scrambler: advances state p by STEP serial bits d[0..STEP-1].
module lfsr_13_step_unroll
  import lfsr_13_pkg::*;
(
  input  logic [WIDTH-1:0] p,
  input  logic [STEP-1:0]  d,
  output logic [WIDTH-1:0] e
);

  logic [WIDTH-1:0] acc;

  // Apply the single-step recurrence STEP times, bit d[0] first.
  always_comb begin
    acc = p;
    for (int k = 0; k < STEP; k++) begin
      acc = lfsr_step(acc, d[k]);
    end
    e = acc;
  end

endmodule

// File: rtl/lfsr_13_descrambler.sv
// Receive-side descrambler: recovers the serial bits from consecutive scrambler states,
// checks each beat against the recurrence, and tracks lock and error statistics.
module lfsr_13_descrambler
  import lfsr_13_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [STEP-1:0]  serial_out,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  desc_state_e        state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               out_valid_q, out_valid_d;
  logic [STEP-1:0]    serial_q, serial_d;
  logic               out_err_q, out_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CLEAN_W-1:0] clean_q, clean_d;
  logic               locked_q, locked_d;

  logic [STEP-1:0]    d_rec;
  logic [WIDTH-1:0]   expected;
  logic               accept;
  logic               mismatch;

  // The top STEP bits carry no taps, so each absorbed bit is the old msb xor where it landed.
  always_comb begin
    d_rec = '0;
    for (int k = 0; k < STEP; k++) begin
      d_rec[k] = state_in[STEP-1-k] ^ prev_q[WIDTH-1-k];
    end
  end

  lfsr_13_step_unroll u_unroll (
    .p (prev_q),
    .d (d_rec),
    .e (expected)
  );

  assign mismatch = (expected != state_in);
  assign in_ready = (state_q == ST_RUN) && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state: FSM, output register handoff, resync to received state, counters.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    serial_d    = serial_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    clean_d     = clean_q;
    locked_d    = locked_q;

    if (accept) begin
      prev_d      = state_in;
      out_valid_d = 1'b1;
      serial_d    = d_rec;
      out_err_d   = mismatch;
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
        clean_d  = '0;
        locked_d = 1'b0;
      end else begin
        if (clean_q != CLEAN_W'(LOCK_N)) clean_d = clean_q + CLEAN_W'(1);
        locked_d = (clean_d == CLEAN_W'(LOCK_N));
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Seeding never coincides with an accept because in_ready is held low.
    if (seed_load) begin
      state_d  = ST_RUN;
      prev_d   = seed_in;
      clean_d  = '0;
      locked_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_UNSEEDED;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      serial_q    <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
      clean_q     <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      serial_q    <= serial_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
      clean_q     <= clean_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign serial_out = serial_q;
  assign out_err    = out_err_q;
  assign err_count  = err_count_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_lfsr_13_descrambler.sv
// Directed self-checking bench for lfsr_13_descrambler.
module tb_lfsr_13_descrambler;
  import lfsr_13_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] state_in;
  logic             out_valid;
  logic             out_ready;
  logic [STEP-1:0]  serial_out;
  logic             out_err;
  logic [ERR_W-1:0] err_count;
  logic             locked;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_13_descrambler dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .serial_out (serial_out),
    .out_err    (out_err),
    .err_count  (err_count),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [STEP-1:0] rev14(input logic [STEP-1:0] v);
    logic [STEP-1:0] r;
    for (int k = 0; k < STEP; k++) r[STEP-1-k] = v[k];
    return r;
  endfunction

  task automatic do_seed(input logic [WIDTH-1:0] v);
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = v;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Present one beat with out_ready high; returns half a cycle after the result registers.
  task automatic send_beat(input string tag, input logic [WIDTH-1:0] n);
    @(negedge clk);
    in_valid  = 1'b1;
    state_in  = n;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] n_msb;
  logic [WIDTH-1:0] nv[6];
  logic [STEP-1:0]  dv[6];
  logic             ev[6];
  logic             lv[6];
  logic [ERR_W-1:0] cv[6];
  logic [WIDTH-1:0] p;
  int               sent;
  int               recv;

  initial begin
    one       = {{(WIDTH-1){1'b0}}, 1'b1};
    n_msb     = (one << 13) | (one << 182) | (one << 296) | (one << 414);
    rst       = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    in_valid  = 1'b1;
    state_in  = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_serial", 32'(serial_out), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("unseeded_in_ready", 32'(in_ready), 32'd0);
    chk("unseeded_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // Zero seed, single bit
    do_seed('0);
    send_beat("zero", one << 13);
    chk("zero_out_valid", 32'(out_valid), 32'd1);
    chk("zero_serial", 32'(serial_out), 32'h0001);
    chk("zero_out_err", 32'(out_err), 32'd0);
    chk("zero_err_count", 32'(err_count), 32'd0);

    // Msb seed exercises all three taps
    do_seed(one << 527);
    send_beat("msb", n_msb);
    chk("msb_serial", 32'(serial_out), 32'h0000);
    chk("msb_out_err", 32'(out_err), 32'd0);

    // Corrupted beat
    do_seed('0);
    send_beat("corrupt", (one << 200) | (one << 13));
    chk("corrupt_serial", 32'(serial_out), 32'h0001);
    chk("corrupt_out_err", 32'(out_err), 32'd1);
    chk("corrupt_err_count", 32'(err_count), 32'd1);
    chk("corrupt_locked", 32'(locked), 32'd0);

    // Lock and backpressure: from seed 0 with msb region clear, N = (P<<14) | rev(d)
    dv[0] = 14'h0001; dv[1] = 14'h1234; dv[2] = 14'h2aaa;
    dv[3] = 14'h0f0f; dv[4] = 14'h3fff; dv[5] = 14'h0155;
    p = '0;
    for (int j = 0; j < 6; j++) begin
      nv[j] = (p << STEP) | {{(WIDTH-STEP){1'b0}}, rev14(dv[j])};
      if (j == 4) nv[j] = nv[j] | (one << 200);
      p = nv[j];
    end
    ev[0] = 0; ev[1] = 0; ev[2] = 0; ev[3] = 0; ev[4] = 1; ev[5] = 0;
    lv[0] = 0; lv[1] = 0; lv[2] = 0; lv[3] = 1; lv[4] = 0; lv[5] = 0;
    cv[0] = 1; cv[1] = 1; cv[2] = 1; cv[3] = 1; cv[4] = 2; cv[5] = 2;
    do_seed('0);
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 6);
      if (sent < 6) state_in = nv[sent];
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("lock_serial_%0d", recv), 32'(serial_out), 32'(dv[recv]));
        chk($sformatf("lock_out_err_%0d", recv), 32'(out_err), 32'(ev[recv]));
        chk($sformatf("lock_locked_%0d", recv), 32'(locked), 32'(lv[recv]));
        chk($sformatf("lock_err_count_%0d", recv), 32'(err_count), 32'(cv[recv]));
        recv++;
      end
      if (out_valid && !out_ready) chk("held_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) sent++;
      if (recv == 6) break;
    end
    chk("lock_sent", 32'(sent), 32'd6);
    chk("lock_recv", 32'(recv), 32'd6);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("lock_no_dup", 32'(out_valid), 32'd0);

    // Seed collision: seed wins, beat is not taken
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = one << 527;
    in_valid  = 1'b1;
    state_in  = n_msb;
    out_ready = 1'b1;
    #1;
    chk("collide_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    seed_load = 1'b0;
    #1;
    chk("collide_no_out", 32'(out_valid), 32'd0);
    chk("collide_retry_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("collide_out_valid", 32'(out_valid), 32'd1);
    chk("collide_serial", 32'(serial_out), 32'h0000);
    chk("collide_out_err", 32'(out_err), 32'd0);
    chk("collide_err_count", 32'(err_count), 32'd2);

    // Reset mid-stream while the output is held
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    state_in = one << 13;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_serial", 32'(serial_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    do_seed('0);
    send_beat("reseed", one << 13);
    chk("reseed_serial", 32'(serial_out), 32'h0001);
    chk("reseed_out_err", 32'(out_err), 32'd0);
    chk("reseed_err_count", 32'(err_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
